// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the memory-level responder: response codes,
// channel FSM state types and the address-window decode helper.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_LAT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LAT, R_RESP} r_state_t;

  function automatic logic addr_in_range(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between the L1 master port and the memory responder.
interface axi_lite_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_mem_slave_array.sv
// Word array with one byte-enabled write port and one registered read port;
// a same-edge read of the word being written returns the old contents.
module axi_mem_array #(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic             rclr,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);
  logic [31:0] mem [WORDS];
  logic [31:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rclr)    rdata_d = '0;
    else if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) rdata_q <= rdata_d;

  assign rdata = rdata_q;
endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory responder behind the L1 cache: one outstanding read and one
// outstanding write, each with a fixed response latency; out-of-range is SLVERR.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           MEM_BYTES  = 16384,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           RD_LATENCY = 4,
  parameter int unsigned           WR_LATENCY = 2
) (
  input logic                 s_axi_aclk,
  input logic                 s_axi_areset,
  axi_lite_mem_slave_if.slave s_axi
);
  localparam int unsigned WORDS   = MEM_BYTES / 4;
  localparam int unsigned IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]  WR_LOAD = 4'(WR_LATENCY - 1);
  localparam logic [3:0]  RD_LOAD = 4'(RD_LATENCY - 1);

  if (DATA_WIDTH != 32 || MEM_BYTES < 4 || (MEM_BYTES & (MEM_BYTES - 1)) != 0 ||
      RD_LATENCY < 1 || RD_LATENCY > 15 || WR_LATENCY < 1 || WR_LATENCY > 15) begin : g_param_check
    $error("axi_lite_mem_slave: unsupported parameterisation");
  end

  w_state_t              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d, w_cnt_q, w_cnt_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  w_in_range, mem_we;
  logic [IDX_W-1:0]      mem_widx;

  r_state_t              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  r_sample, r_in_range, mem_re, mem_rclr;
  logic [IDX_W-1:0]      mem_ridx;

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    w_cnt_d   = w_cnt_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (awready_q && s_axi.awvalid) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.awaddr;
        end
        if (wready_q && s_axi.wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.wdata;
          wstrb_d  = s_axi.wstrb;
        end
        if (aw_held_d && w_held_d) begin
          w_state_d = W_LAT;
          w_cnt_d   = WR_LOAD;
        end
      end
      W_LAT: begin
        if (w_cnt_q == '0) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = w_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          w_cnt_d = w_cnt_q - 4'd1;
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE) && !aw_held_d;
    wready_d  = (w_state_d == W_IDLE) && !w_held_d;
  end

  // Commit on the edge that leaves the counter at zero, one edge before bvalid;
  // with WR_LATENCY=1 that is the capture edge itself, hence the _d operands.
  assign w_in_range = addr_in_range(64'(awaddr_d), 64'(BASE_ADDR), 64'(MEM_BYTES));
  assign mem_widx   = IDX_W'((awaddr_d - BASE_ADDR) >> 2);
  assign mem_we     = !s_axi_areset && (w_state_d == W_LAT) && (w_cnt_d == '0) && w_in_range;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      w_cnt_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      w_cnt_q   <= w_cnt_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    araddr_d  = araddr_q;
    r_cnt_d   = r_cnt_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    r_sample  = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (arready_q && s_axi.arvalid) begin
          araddr_d  = s_axi.araddr;
          r_state_d = R_LAT;
          r_cnt_d   = RD_LOAD;
        end
      end
      R_LAT: begin
        if (r_cnt_q == '0) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          r_sample  = 1'b1;
          rresp_d   = r_in_range ? RESP_OKAY : RESP_SLVERR;
        end else begin
          r_cnt_d = r_cnt_q - 4'd1;
        end
      end
      R_RESP: begin
        if (s_axi.rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  assign r_in_range = addr_in_range(64'(araddr_q), 64'(BASE_ADDR), 64'(MEM_BYTES));
  assign mem_ridx   = IDX_W'((araddr_q - BASE_ADDR) >> 2);
  assign mem_re     = !s_axi_areset && r_sample && r_in_range;
  assign mem_rclr   = s_axi_areset || (r_sample && !r_in_range);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state_q <= R_IDLE;
      araddr_q  <= '0;
      r_cnt_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      araddr_q  <= araddr_d;
      r_cnt_q   <= r_cnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
    end
  end

  axi_mem_array #(
    .WORDS (WORDS),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (s_axi_aclk),
    .we    (mem_we),
    .waddr (mem_widx),
    .wdata (wdata_d),
    .wstrb (wstrb_d),
    .re    (mem_re),
    .rclr  (mem_rclr),
    .raddr (mem_ridx),
    .rdata (s_axi.rdata)
  );

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: directed scenarios plus randomized traffic
// against a byte-level memory model.
module tb_axi_lite_mem_slave;
  import axi_lite_pkg::*;

  localparam int unsigned MEM_BYTES = 16384;
  localparam int unsigned RD_LAT    = 4;
  localparam int unsigned WR_LAT    = 2;
  localparam int unsigned TMO       = 64;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] ref_mem [MEM_BYTES/4];

  axi_lite_mem_slave_if #(.ADDR_WIDTH(32)) bus ();

  axi_lite_mem_slave #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_BYTES  (MEM_BYTES),
    .BASE_ADDR  (32'h0000_0000),
    .RD_LATENCY (RD_LAT),
    .WR_LATENCY (WR_LAT)
  ) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .s_axi        (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    if (a >= MEM_BYTES) return RESP_SLVERR;
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a / 4][8*b +: 8] = d[8*b +: 8];
    return RESP_OKAY;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] a);
    return (a < MEM_BYTES) ? ref_mem[a / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] model_rresp(input logic [31:0] a);
    return (a < MEM_BYTES) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  task automatic wait_b(input string tag, input logic [1:0] exp);
    int unsigned n = 0;
    while (!bus.bvalid && n < TMO) begin step(); n++; end
    check({tag, "_b_lat"}, n, WR_LAT);
    check({tag, "_bresp"}, 32'(bus.bresp), 32'(exp));
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check({tag, "_b_drop"}, 32'(bus.bvalid), 32'd0);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic aw_done, w_done, hs_aw, hs_w;
    logic [1:0] exp;
    int unsigned n;
    exp = model_write(a, d, s);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    aw_done = 1'b0; w_done = 1'b0; n = 0;
    while (!(aw_done && w_done) && n < TMO) begin
      hs_aw = bus.awvalid && bus.awready;
      hs_w  = bus.wvalid && bus.wready;
      step();
      n++;
      if (hs_aw) begin aw_done = 1'b1; bus.awvalid = 1'b0; end
      if (hs_w)  begin w_done  = 1'b1; bus.wvalid  = 1'b0; end
    end
    check({tag, "_aw_w_hs"}, 32'(aw_done && w_done), 32'd1);
    wait_b(tag, exp);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a,
                         input logic [31:0] exp_d, input logic [1:0] exp_r);
    logic done, hs;
    int unsigned n;
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < TMO) begin
      hs = bus.arvalid && bus.arready;
      step();
      n++;
      if (hs) begin done = 1'b1; bus.arvalid = 1'b0; end
    end
    check({tag, "_ar_hs"}, 32'(done), 32'd1);
    n = 0;
    while (!bus.rvalid && n < TMO) begin step(); n++; end
    check({tag, "_r_lat"}, n, RD_LAT);
    check({tag, "_rresp"}, 32'(bus.rresp), 32'(exp_r));
    check({tag, "_rdata"}, bus.rdata, exp_d);
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    check({tag, "_r_drop"}, 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] pool [8];
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        stable;
    int unsigned n;

    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    check("rst_hs_outputs", 32'({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid}), 32'd0);
    check("rst_resps", 32'({bus.bresp, bus.rresp}), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    step();
    check("rst_release_ready", 32'({bus.awready, bus.wready, bus.arready}), 32'b111);

    do_write("basic_wr", 32'h100, 32'hDEAD_BEEF, 4'hF);
    do_read("basic_rd", 32'h100, 32'hDEAD_BEEF, RESP_OKAY);

    do_write("strb_pre", 32'h40, 32'hAAAA_AAAA, 4'hF);
    do_write("strb_wr", 32'h40, 32'h1122_3344, 4'h5);
    do_read("strb_rd", 32'h40, 32'hAA22_AA44, RESP_OKAY);

    // W leads AW by three cycles; B is then held off while a read completes
    bus.bready = 1'b0;
    bus.awaddr = 32'h300; bus.wdata = 32'h5A5A_0F0F; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    step();
    bus.wvalid = 1'b0;
    check("split_wready_low", 32'(bus.wready), 32'd0);
    step(); step();
    check("split_awready_high", 32'(bus.awready), 32'd1);
    bus.awvalid = 1'b1;
    step();
    bus.awvalid = 1'b0;
    check("split_awready_low", 32'(bus.awready), 32'd0);
    void'(model_write(32'h300, 32'h5A5A_0F0F, 4'hF));
    n = 0;
    while (!bus.bvalid && n < TMO) begin step(); n++; end
    check("split_b_lat", n, WR_LAT);
    stable = 1'b1;
    repeat (5) begin
      step();
      if (!(bus.bvalid === 1'b1 && bus.bresp === RESP_OKAY && bus.awready === 1'b0)) stable = 1'b0;
    end
    check("split_b_stable", 32'(stable), 32'd1);
    do_read("stall_rd", 32'h100, model_rdata(32'h100), RESP_OKAY);
    check("split_b_held", 32'({bus.bvalid, bus.bresp}), 32'({1'b1, RESP_OKAY}));
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check("split_awready_after_b", 32'({bus.awready, bus.bvalid}), 32'b10);
    do_read("split_rd", 32'h300, 32'h5A5A_0F0F, RESP_OKAY);

    do_write("oor_w0", 32'h0, 32'h0BAD_F00D, 4'hF);
    do_read("oor_rd", MEM_BYTES, 32'h0, RESP_SLVERR);
    do_write("oor_wr", MEM_BYTES, 32'hFFFF_FFFF, 4'hF);
    do_read("oor_w0_rd", 32'h0, 32'h0BAD_F00D, RESP_OKAY);

    // AR at edge E, AW/W at E+3: write commit and read sample share edge E+4
    do_write("col_pre", 32'h200, 32'h0, 4'hF);
    bus.araddr = 32'h200; bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    step(); step();
    bus.awaddr = 32'h200; bus.wdata = 32'hC0FF_EE11; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    check("col_rvalid_early", 32'(bus.rvalid), 32'd0);
    step();
    check("col_rvalid", 32'(bus.rvalid), 32'd1);
    check("col_rdata_old", bus.rdata, 32'h0);
    check("col_rresp", 32'(bus.rresp), 32'(RESP_OKAY));
    step();
    check("col_bvalid", 32'({bus.bvalid, bus.bresp}), 32'({1'b1, RESP_OKAY}));
    bus.rready = 1'b1; bus.bready = 1'b1;
    step();
    bus.rready = 1'b0; bus.bready = 1'b0;
    void'(model_write(32'h200, 32'hC0FF_EE11, 4'hF));
    do_read("col_new", 32'h200, 32'hC0FF_EE11, RESP_OKAY);

    bus.araddr = 32'h100; bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_ready_in_rst", 32'(bus.arready), 32'd0);
    step();
    check("rstmid_arready", 32'(bus.arready), 32'd1);
    stable = 1'b1;
    repeat (RD_LAT + 2) begin
      if (bus.rvalid !== 1'b0) stable = 1'b0;
      step();
    end
    check("rstmid_no_rvalid", 32'(stable), 32'd1);
    do_read("rstmid_rd", 32'h100, 32'hDEAD_BEEF, RESP_OKAY);

    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'($urandom_range(0, MEM_BYTES/4 - 1)) << 2;
      do_write("rnd_init", pool[i], $urandom, 4'hF);
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? (MEM_BYTES + ($urandom_range(0, 255) << 2)) : 32'hFFFF_FFFC;
      else
        a = pool[$urandom_range(0, 7)] + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write("rnd_wr", a, d, s);
      end else begin
        do_read("rnd_rd", a, model_rdata(a), model_rresp(a));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
